// File: rtl/audio_pkg.sv
// Shared definitions for the audio blocks: tone FSM states and the
// half-period calculation used to size the tone counter.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } tone_state_t;

  function automatic int half0_calc(input int clk_hz, input int base_hz);
    return clk_hz / (2 * base_hz);
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Control/output bundle of tone_synth: play request, tone settings and audio pins.
interface tone_synth_if #(
  parameter int SEL_W = 3,
  parameter int VOL_W = 4
);
  logic             en;
  logic [SEL_W-1:0] sel;
  logic [VOL_W-1:0] vol;
  logic             pwmPin;
  logic             ampPin;
  logic             busy;

  modport master (output en, sel, vol, input pwmPin, ampPin, busy);
  modport slave  (input en, sel, vol, output pwmPin, ampPin, busy);
endinterface

// File: rtl/tone_synth_pwm_carrier.sv
// Free-running VOL_W-bit PWM carrier; `carrier` compares the count the
// register is about to take, so the caller can register it in lockstep.
module pwm_carrier #(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [VOL_W-1:0] duty,
  output logic             carrier
);

  logic [VOL_W-1:0] pc_q;
  logic [VOL_W-1:0] pc_d;

  always_comb begin
    if (clr) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + VOL_W'(1);
    end
    carrier = (pc_d < duty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Octave-spaced square-wave tone generator with PWM volume and clean drain.
// Optional macro TONE_SYNTH_FADE_EN: fade volume one step per period while draining.
module tone_synth
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BASE_HZ   = 4000,
  parameter int NUM_TONES = 8,
  parameter int VOL_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  tone_synth_if.slave  bus
);

  localparam int HALF0 = half0_calc(CLK_HZ, BASE_HZ);
  localparam int SEL_W = $clog2(NUM_TONES);
  localparam int CNT_W = $clog2(HALF0 << (NUM_TONES - 1));

  tone_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic             pwm_q, pwm_d;
  logic             amp_q, amp_d;
  logic             busy_q, busy_d;

  logic [CNT_W:0]   half_s;
  logic [CNT_W-1:0] last_s;
  logic [SEL_W-1:0] sel_clamp_s;
  logic             wrap_s;
  logic             boundary_s;
  logic             start_s;
  logic             active_s;
  logic             carrier_s;

  assign half_s      = (CNT_W + 1)'(HALF0) << sel_q;
  assign last_s      = CNT_W'(half_s - (CNT_W + 1)'(1));
  assign wrap_s      = (cnt_q == last_s);
  assign boundary_s  = wrap_s & ~phase_q;
  assign sel_clamp_s = ({1'b0, bus.sel} >= (SEL_W + 1)'(NUM_TONES)) ?
                       SEL_W'(NUM_TONES - 1) : bus.sel;

  // Next state, tone counter, settings and registered pin values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    vol_d   = vol_q;
    start_s = 1'b0;

    if (wrap_s) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        if (bus.en) begin
          state_d = PLAY;
          start_s = 1'b1;
          phase_d = 1'b1;
          sel_d   = sel_clamp_s;
          vol_d   = bus.vol;
        end else begin
          phase_d = 1'b0;
        end
      end
      PLAY: begin
        if (!bus.en) begin
          state_d = DRAIN;
        end else if (boundary_s) begin
          sel_d = sel_clamp_s;
          vol_d = bus.vol;
        end else begin
          state_d = PLAY;
        end
      end
      DRAIN: begin
        if (bus.en) begin
          state_d = PLAY;
        end else if (boundary_s) begin
`ifdef TONE_SYNTH_FADE_EN
          if (vol_q == VOL_W'(0)) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            vol_d = vol_q - VOL_W'(1);
          end
`else
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
`endif
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase

    // Pins follow the state being entered so they line up with phase/carrier
    active_s = (state_d != IDLE);
    pwm_d    = active_s & phase_d & carrier_s;
    amp_d    = active_s;
    busy_d   = active_s;
  end

  pwm_carrier #(.VOL_W(VOL_W)) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_s),
    .duty    (vol_d),
    .carrier (carrier_s)
  );

  // State, tone and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      sel_q   <= '0;
      vol_q   <= '0;
      pwm_q   <= 1'b0;
      amp_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      vol_q   <= vol_d;
      pwm_q   <= pwm_d;
      amp_q   <= amp_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.pwmPin = pwm_q;
  assign bus.ampPin = amp_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth with HALF0=4, five tones, 2-bit volume.
module tb_tone_synth;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  tone_synth_if #(.SEL_W(3), .VOL_W(2)) bus ();

  tone_synth #(
    .CLK_HZ    (1000),
    .BASE_HZ   (125),
    .NUM_TONES (5),
    .VOL_W     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pins(input string tag, input logic p, input logic a, input logic b);
    chk({tag, ".pwm"}, {31'd0, bus.pwmPin}, {31'd0, p});
    chk({tag, ".amp"}, {31'd0, bus.ampPin}, {31'd0, a});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
  endtask

  // one clock, then sample on the falling edge
  task automatic cyc(input string tag, input logic p, input logic a, input logic b);
    @(negedge clk);
    pins(tag, p, a, b);
  endtask

  // high half: carrier count runs 0..3 aligned to the half start
  task automatic high_half(input string tag, input int n, input int v, input int off);
    for (int i = 0; i < n; i++) begin
      cyc(tag, (((off + i) % 4) < v), 1'b1, 1'b1);
    end
  endtask

  task automatic low_half(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b1;
    bus.sel = 3'd0;
    bus.vol = 2'd3;

    // reset held with en high: everything stays quiet
    repeat (3) cyc("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // tone 0, vol 3: 1110 then 0000
    cyc("start", 1'b1, 1'b1, 1'b1);
    cyc("t0", 1'b1, 1'b1, 1'b1);
    cyc("t0", 1'b1, 1'b1, 1'b1);
    cyc("t0", 1'b0, 1'b1, 1'b1);
    low_half("t0_low", 4);
    high_half("t0_p2", 4, 3, 0);
    low_half("t0_p2low", 4);

    // sel change mid-high-half: current period stays 8 cycles
    high_half("t0_p3", 2, 3, 0);
    bus.sel = 3'd2;
    high_half("t0_p3", 2, 3, 2);
    low_half("t0_p3low", 4);
    high_half("t2_high", 6, 3, 0);
    bus.sel = 3'd7;
    bus.vol = 2'd1;
    high_half("t2_high", 10, 3, 6);
    low_half("t2_low", 16);

    // sel 7 clamps to tone 4: 64-cycle halves, vol 1
    high_half("t4_high", 64, 1, 0);
    low_half("t4_low", 64);
    high_half("t4_p2", 5, 1, 0);

    // asynchronous reset mid-high-half
    #2;
    rst = 1'b1;
    #1;
    pins("async_rst", 1'b0, 1'b0, 1'b0);
    bus.sel = 3'd0;
    bus.vol = 2'd3;
    @(negedge clk);
    pins("rst_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    high_half("restart", 4, 3, 0);
    low_half("restart_low", 4);
    high_half("drain_pre", 2, 3, 0);
    bus.en = 1'b0;

`ifdef TONE_SYNTH_FADE_EN
    high_half("fade3", 2, 3, 2);
    low_half("fade3_low", 4);
    high_half("fade2", 4, 2, 0);
    low_half("fade2_low", 4);
    high_half("fade1", 4, 1, 0);
    low_half("fade1_low", 4);
    high_half("fade0", 4, 0, 0);
    low_half("fade0_low", 4);
    cyc("fade_end", 1'b0, 1'b0, 1'b0);
    cyc("fade_idle", 1'b0, 1'b0, 1'b0);
`else
    high_half("drain", 2, 3, 2);
    low_half("drain_low", 4);
    cyc("drain_end", 1'b0, 1'b0, 1'b0);
    cyc("drain_idle", 1'b0, 1'b0, 1'b0);
`endif

    // en re-raised during DRAIN: tone carries on without restarting
    bus.en = 1'b1;
    high_half("rr_start", 2, 3, 0);
    bus.en = 1'b0;
    high_half("rr_drain", 2, 3, 2);
    low_half("rr_drain_low", 1);
    bus.en = 1'b1;
    low_half("rr_resume_low", 3);
    high_half("rr_high", 4, 3, 0);
    low_half("rr_low", 4);
    high_half("rr_p3", 2, 3, 0);

`ifndef TONE_SYNTH_FADE_EN
    // en drop coincides with boundary: vol not reloaded, drain lasts a full period
    high_half("sim_pre", 2, 3, 2);
    low_half("sim_pre_low", 4);
    bus.en  = 1'b0;
    bus.vol = 2'd1;
    high_half("sim_drain", 4, 3, 0);
    low_half("sim_drain_low", 4);
    cyc("sim_end", 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
